pipe_mul: RTL



---
 rtl/pipe_mul.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pipe_mul.sv
// Fully pipelined XLEN-bit multiplier (MUL/MULH/MULHSU/MULHU) with tag tracking and early wakeup.
// Define MUL_PERF_CNT_EN to add the issue/kill performance counters.
module pipe_mul #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned LATENCY = 4,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_i,
    input  logic             kill_i,
    input  logic             req_i,
    input  logic [1:0]       op_sel_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             ready_o,
    output logic             result_valid_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] result_tag_o,
    output logic             early_wake_up_o,
    output logic [TAG_W-1:0] early_tag_o,
    output logic             busy_o
`ifdef MUL_PERF_CNT_EN
    ,
    output logic [31:0]      perf_issue_cnt_o,
    output logic [31:0]      perf_kill_cnt_o
`endif
);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    localparam int unsigned PW = 2 * XLEN;

    logic               accept;
    op_e                op_in;
    logic               sgn_a;
    logic               sgn_b;
    logic [LATENCY-1:0] vld;
    op_e                op    [LATENCY-1];
    logic               neg_a [LATENCY-1];
    logic               neg_b [LATENCY-1];
    logic [TAG_W-1:0]   tag   [LATENCY];
    logic [XLEN-1:0]    mag_a;
    logic [XLEN-1:0]    mag_b;
    logic [PW-1:0]      last_prod;
    logic [PW-1:0]      signed_prod;
    logic [XLEN-1:0]    result_next;

    always_comb begin
        op_in  = op_e'(op_sel_i);
        accept = req_i & ~stall_i & ~kill_i;
        sgn_a  = a_i[XLEN-1] & ((op_in == OP_MULH) | (op_in == OP_MULHSU));
        sgn_b  = b_i[XLEN-1] & (op_in == OP_MULH);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld <= '0;
        end else if (kill_i) begin
            vld <= '0;
        end else if (!stall_i) begin
            vld <= {vld[LATENCY-2:0], accept};
        end
    end

    // Data registers only load behind a valid op, so idle stages and the outputs stay quiet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mag_a    <= '0;
            mag_b    <= '0;
            result_o <= '0;
            for (int unsigned i = 0; i < LATENCY - 1; i++) begin
                op[i]    <= OP_MUL;
                neg_a[i] <= 1'b0;
                neg_b[i] <= 1'b0;
            end
            for (int unsigned i = 0; i < LATENCY; i++) begin
                tag[i] <= '0;
            end
        end else if (!stall_i) begin
            if (accept) begin
                mag_a    <= sgn_a ? -a_i : a_i;
                mag_b    <= sgn_b ? -b_i : b_i;
                op[0]    <= op_in;
                neg_a[0] <= sgn_a;
                neg_b[0] <= sgn_b;
                tag[0]   <= tag_i;
            end
            for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                if (vld[i-1]) begin
                    op[i]    <= op[i-1];
                    neg_a[i] <= neg_a[i-1];
                    neg_b[i] <= neg_b[i-1];
                end
            end
            for (int unsigned i = 1; i < LATENCY; i++) begin
                if (vld[i-1]) begin
                    tag[i] <= tag[i-1];
                end
            end
            if (vld[LATENCY-2]) begin
                result_o <= result_next;
            end
        end
    end

    // The magnitude product is registered through stages 1..LATENCY-2 so the multiplier can be retimed into DSPs.
    generate
        if (LATENCY == 2) begin : g_direct
            always_comb last_prod = PW'(mag_a) * PW'(mag_b);
        end else begin : g_retime
            logic [PW-1:0] prod_pipe [LATENCY-2];

            always_ff @(posedge clk_i) begin
                if (!stall_i) begin
                    if (vld[0]) begin
                        prod_pipe[0] <= PW'(mag_a) * PW'(mag_b);
                    end
                    for (int unsigned k = 1; k < LATENCY - 2; k++) begin
                        if (vld[k]) begin
                            prod_pipe[k] <= prod_pipe[k-1];
                        end
                    end
                end
            end

            always_comb last_prod = prod_pipe[LATENCY-3];
        end
    endgenerate

    always_comb begin
        signed_prod = (neg_a[LATENCY-2] ^ neg_b[LATENCY-2]) ? -last_prod : last_prod;
        result_next = (op[LATENCY-2] == OP_MUL) ? signed_prod[XLEN-1:0] : signed_prod[PW-1:XLEN];
    end

    always_comb begin
        ready_o         = ~stall_i;
        result_valid_o  = vld[LATENCY-1];
        result_tag_o    = tag[LATENCY-1];
        early_wake_up_o = vld[LATENCY-2] & ~kill_i;
        early_tag_o     = tag[LATENCY-2];
        busy_o          = |vld;
    end

`ifdef MUL_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_issue_cnt_o <= '0;
            perf_kill_cnt_o  <= '0;
        end else begin
            if (accept) begin
                perf_issue_cnt_o <= perf_issue_cnt_o + 32'd1;
            end
            if (kill_i) begin
                perf_kill_cnt_o <= perf_kill_cnt_o + 32'($countones(vld));
            end
        end
    end
`endif

endmodule
